// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// iteration count and small op-decode helpers used by the datapath and decoder.
package muldiv_sequencer_pkg;

    localparam int MD_STEPS = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Ops that go through the 32-step iterate loop
    function automatic logic md_is_iter(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_sign_fix.sv
// Final sign correction for the sequencer: turns the unsigned magnitude result
// held in the accumulator into the architectural HI/LO values.
module muldiv_sequencer_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic               neg_main,
    input  logic               neg_rem,
    input  logic               div_zero,
    input  logic [2*WIDTH-1:0] acc,
    output logic [WIDTH-1:0]   hi_fix,
    output logic [WIDTH-1:0]   lo_fix
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Negate product / quotient / remainder as required, then select by op class.
    // A zero divisor always yields an all-ones quotient regardless of operand signs.
    always_comb begin
        prod = neg_main ? -acc : acc;
        quo  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            hi_fix = rem;
            lo_fix = div_zero ? '1 : quo;
        end else begin
            hi_fix = prod[2*WIDTH-1:WIDTH];
            lo_fix = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit with architectural HI/LO.
// state   | meaning
// MD_IDLE | waiting for start; MTHI/MTLO complete here in one cycle
// MD_RUN  | 32 shift-add (mul) or restoring-divide steps on magnitudes
// MD_FIX  | sign correction and HI/LO writeback; done pulses next cycle
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = MD_STEPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    md_state_e          state;
    logic [CW-1:0]      step_cnt;
    // mul: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;
    // multiplicand magnitude for mul, divisor magnitude for div
    logic [WIDTH-1:0]   operand;
    logic               is_div_q;
    logic               neg_main_q;
    logic               neg_rem_q;
    logic               div_zero_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    // Operand magnitudes; unsigned ops pass the raw operands through.
    always_comb begin
        a_neg = md_is_signed(op) && A[WIDTH-1];
        b_neg = md_is_signed(op) && B[WIDTH-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
    end

    // One iteration step. The remainder can never exceed the divisor after a
    // subtract, so the low WIDTH bits of the difference are exact.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, operand};
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - operand) : div_shift[WIDTH-1:0];
        if (is_div_q) begin
            acc_next = {div_rem, acc[WIDTH-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    muldiv_sequencer_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_div   (is_div_q),
        .neg_main (neg_main_q),
        .neg_rem  (neg_rem_q),
        .div_zero (div_zero_q),
        .acc      (acc),
        .hi_fix   (hi_fix),
        .lo_fix   (lo_fix)
    );

    // Sequencer: launch, iterate, write back; flush abandons any op without touching HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MD_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_cnt   <= '0;
            acc        <= '0;
            operand    <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state    <= MD_IDLE;
                busy     <= 1'b0;
                step_cnt <= '0;
            end else begin
                case (state)
                    MD_IDLE: begin
                        if (start && md_is_iter(op)) begin
                            acc        <= {{WIDTH{1'b0}}, (md_is_div(op) ? a_mag : b_mag)};
                            operand    <= md_is_div(op) ? b_mag : a_mag;
                            is_div_q   <= md_is_div(op);
                            neg_main_q <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg && md_is_div(op);
                            div_zero_q <= md_is_div(op) && (B == '0);
                            step_cnt   <= '0;
                            busy       <= 1'b1;
                            state      <= MD_RUN;
                        end else if (start && (op == MD_MTHI)) begin
                            hi <= A;
                        end else if (start && (op == MD_MTLO)) begin
                            lo <= A;
                        end
                    end
                    MD_RUN: begin
                        acc      <= acc_next;
                        step_cnt <= step_cnt + CW'(1);
                        if (step_cnt == LAST_STEP) begin
                            state <= MD_FIX;
                        end
                    end
                    MD_FIX: begin
                        hi    <= hi_fix;
                        lo    <= lo_fix;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases with literal results plus random ops
// against an arithmetic reference, with busy/done/HI/LO compared every cycle.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a_in),
        .B     (b_in),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: committed HI/LO and the one op in flight (if any)
    bit          chk_en   = 1'b0;
    bit          m_active = 1'b0;
    int          m_e      = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;
    logic [31:0] m_res_hi = '0;
    logic [31:0] m_res_lo = '0;
    int          busy_cnt = 0;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {hi, lo} an op must produce, from plain signed/unsigned arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            3'd0: p = sa * sb;
            3'd1: p = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare: accepted at edge m_e -> busy cycles m_e..m_e+32, done and result at m_e+33
    initial begin : compare
        logic        eb, ed;
        logic [31:0] eh, el;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                eb = m_active && (cyc >= m_e) && (cyc <= m_e + 32);
                ed = m_active && (cyc == m_e + 33);
                eh = ed ? m_res_hi : m_hi;
                el = ed ? m_res_lo : m_lo;
                chk("busy", {31'b0, busy}, {31'b0, eb});
                chk("done", {31'b0, done}, {31'b0, ed});
                chk("hi", hi, eh);
                chk("lo", lo, el);
                if (ed) begin
                    m_hi     = m_res_hi;
                    m_lo     = m_res_lo;
                    m_active = 1'b0;
                end
                if (busy) busy_cnt++;
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op (MTHI/MTLO/ignored codes), optionally squashed by flush
    task automatic issue_mt(input logic [2:0] o, input logic [31:0] a, input bit with_flush);
        op    = o;
        a_in  = a;
        b_in  = $urandom;
        start = 1'b1;
        flush = with_flush;
        step();
        start = 1'b0;
        flush = 1'b0;
        if (!with_flush) begin
            if (o == 3'd4) m_hi = a;
            if (o == 3'd5) m_lo = a;
        end
    endtask

    // mode 0: plain; 1: flush at busy cycle j; 2: extra start (xo/xa/xb) at busy cycle j;
    // 3: reset at busy cycle j. Returns at the done cycle when the op completes.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mode, input int j, input logic [2:0] xo,
                          input logic [31:0] xa, input logic [31:0] xb, output bit completed);
        logic [63:0] r;
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        step();
        start    = 1'b0;
        r        = ref_result(o, a, b);
        m_res_hi = r[63:32];
        m_res_lo = r[31:0];
        m_e      = cyc;
        m_active = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        completed = 1'b1;
        for (int k = 0; k < 33; k++) begin
            if (mode == 1 && k == j) begin
                flush = 1'b1;
                step();
                flush     = 1'b0;
                m_active  = 1'b0;
                completed = 1'b0;
                return;
            end else if (mode == 3 && k == j) begin
                reset = 1'b1;
                step();
                reset     = 1'b0;
                m_active  = 1'b0;
                m_hi      = '0;
                m_lo      = '0;
                completed = 1'b0;
                return;
            end else if (mode == 2 && k == j) begin
                op    = xo;
                a_in  = xa;
                b_in  = xb;
                start = 1'b1;
                step();
                start = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        chk({name, "_done"}, {31'b0, done}, 32'd1);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
        step();
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        chk({name, "_done_cycles"}, 32'(done_cnt), 32'd1);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          ok;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          roll, mode;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        chk_en = 1'b1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;
        step();

        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 3'd0, 0, 0, ok);
        expect_result("multu_max", 32'hFFFFFFFE, 32'h00000001);
        run_op(3'd0, 32'hFFFFFFFD, 32'd7, 0, 0, 3'd0, 0, 0, ok);
        expect_result("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 3'd0, 0, 0, ok);
        expect_result("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(3'd3, 32'h00001234, 32'd0, 0, 0, 3'd0, 0, 0, ok);
        expect_result("divu_zero", 32'h00001234, 32'hFFFFFFFF);
        run_op(3'd2, 32'hFFFFFFFB, 32'd0, 0, 0, 3'd0, 0, 0, ok);
        expect_result("div_zero_neg", 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 3'd0, 0, 0, ok);
        expect_result("div_ovf", 32'h00000000, 32'h80000000);

        busy_cnt = 0;
        done_cnt = 0;
        issue_mt(3'd4, 32'hCAFEF00D, 1'b0);
        chk("mthi_hi", hi, 32'hCAFEF00D);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        step();
        chk("mthi_no_done", 32'(done_cnt), 32'd0);
        chk("mthi_no_busy", 32'(busy_cnt), 32'd0);

        run_op(3'd1, 32'd5, 32'd6, 2, 5, 3'd0, 32'd7, 32'd9, ok);
        expect_result("start_while_busy", 32'd0, 32'd30);

        issue_mt(3'd4, 32'h13579BDF, 1'b0);
        run_op(3'd2, 32'd1000, 32'd7, 3, 9, 3'd0, 0, 0, ok);
        chk("reset_mid_busy", {31'b0, busy}, 32'd0);
        chk("reset_mid_hi", hi, 32'd0);
        chk("reset_mid_lo", lo, 32'd0);
        step();

        issue_mt(3'd4, 32'h11111111, 1'b0);
        issue_mt(3'd5, 32'h22222222, 1'b0);
        run_op(3'd0, 32'd3, 32'd4, 1, 15, 3'd0, 0, 0, ok);
        step();
        step();
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_hi", hi, 32'h11111111);
        chk("flush_lo", lo, 32'h22222222);
        chk("flush_no_done", 32'(done_cnt), 32'd0);

        issue_mt(3'd5, 32'hDEADBEEF, 1'b1);
        chk("flush_drops_mtlo", lo, 32'h22222222);
        op    = 3'd0;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_drops_start", {31'b0, busy}, 32'd0);
        step();

        for (int n = 0; n < 700; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = rand_operand();
            rb = rand_operand();
            if (ro < 3'd4) begin
                roll = $urandom_range(0, 99);
                mode = (roll < 8) ? 1 : (roll < 18) ? 2 : 0;
                run_op(ro, ra, rb, mode, $urandom_range(0, 32), 3'($urandom_range(0, 7)),
                       $urandom, $urandom, ok);
            end else begin
                issue_mt(ro, ra, $urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 3) == 0) step();
        end
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
